// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared widths, AU opcodes and issue FSM state type
package au_pkg;

    localparam int AU_W    = 24;
    localparam int AU_FRAC = 14;
    localparam int AU_NREG = 8;
    localparam int AU_IW   = 3;

    localparam logic [1:0] CTL_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

endpackage

// File: rtl/au_regfile.sv
// rtl/au_regfile.sv - operand register file: three snapshot read ports, host read, WB-over-host write
module au_regfile
    import au_pkg::*;
#(
    parameter int W    = AU_W,
    parameter int NREG = AU_NREG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snap,
    input  logic [AU_IW-1:0] ra,
    input  logic [AU_IW-1:0] rb,
    input  logic [AU_IW-1:0] rc,
    output logic [W-1:0]     q_r,
    output logic [W-1:0]     q_s,
    output logic [W-1:0]     q_i,
    input  logic             wb_we,
    input  logic [AU_IW-1:0] wb_addr,
    input  logic [W-1:0]     wb_data,
    input  logic             host_we,
    input  logic [AU_IW-1:0] host_addr,
    input  logic [W-1:0]     host_wdata,
    output logic [W-1:0]     host_rdata
);

    logic [W-1:0] mem [NREG];

    assign host_rdata = mem[host_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            q_r <= '0;
            q_s <= '0;
            q_i <= '0;
        end else begin
            if (host_we) begin
                mem[host_addr] <= host_wdata;
            end
            // Later assignment wins, so a same-address writeback overrides the host.
            if (wb_we) begin
                mem[wb_addr] <= wb_data;
            end
            if (snap) begin
                q_r <= mem[ra];
                q_s <= mem[rb];
                q_i <= mem[rc];
            end
        end
    end

endmodule

// File: rtl/au_issue.sv
// rtl/au_issue.sv - single-command issue unit for the AU; AU_ISSUE_TIMEOUT_EN adds a WAIT timeout
module au_issue
    import au_pkg::*;
#(
    parameter int W    = AU_W,
    parameter int FRAC = AU_FRAC,
    parameter int NREG = AU_NREG,
    parameter int TMO  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [8:0]       cmd_src,
    input  logic [AU_IW-1:0] cmd_rd,
    output logic             au_start,
    output logic [W-1:0]     au_r,
    output logic [W-1:0]     au_s,
    output logic [W-1:0]     au_i,
    output logic [1:0]       au_ctl_d,
    input  logic [W-1:0]     au_result,
    input  logic             au_done,
    input  logic             au_busy,
    output logic             cpl_valid,
    output logic [AU_IW-1:0] cpl_rd,
    output logic             cpl_err,
    input  logic             host_we,
    input  logic [AU_IW-1:0] host_addr,
    input  logic [W-1:0]     host_wdata,
    output logic [W-1:0]     host_rdata
);

    if (FRAC >= W || TMO < 1 || NREG > (1 << AU_IW)) begin : g_bad_cfg
        $error("au_issue: invalid parameter set");
    end

    state_t           state;
    logic             start_q;
    logic [1:0]       op_q;
    logic [AU_IW-1:0] rd_q;
    logic [W-1:0]     res_q;
    logic             snap;
    logic             wb_we;

    assign cmd_ready = (state == ST_IDLE);
    assign snap      = cmd_ready && cmd_valid;
    assign au_start  = start_q;
    assign au_ctl_d  = op_q;
    assign cpl_valid = (state == ST_WB);
    assign cpl_rd    = cpl_valid ? rd_q : '0;
    assign wb_we     = cpl_valid && !cpl_err;

`ifdef AU_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          err_q;

    assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
    assign cpl_err = cpl_valid && err_q;

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign cpl_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            res_q   <= '0;
`ifdef AU_ISSUE_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        state <= ST_ISSUE;
`ifdef AU_ISSUE_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    // Start is registered: the pulse lasts exactly the cycle before WAIT.
                    if (start_q) begin
                        state <= ST_WAIT;
                    end else if (!au_busy) begin
                        start_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (au_done) begin
                        res_q <= au_result;
                        state <= ST_WB;
                    end
`ifdef AU_ISSUE_TIMEOUT_EN
                    else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= ST_WB;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    au_regfile #(
        .W    (W),
        .NREG (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .snap       (snap),
        .ra         (cmd_src[8:6]),
        .rb         (cmd_src[5:3]),
        .rc         (cmd_src[2:0]),
        .q_r        (au_r),
        .q_s        (au_s),
        .q_i        (au_i),
        .wb_we      (wb_we),
        .wb_addr    (rd_q),
        .wb_data    (res_q),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

endmodule

// File: doc/au_issue.md
AU_ISSUE -- requirements
Module: au_issue

Interface
REQ-001 Parameter W, default 24: operand/result width, sign-magnitude Q9.14.
REQ-002 Parameter FRAC, default 14: fraction bits; passed through only, no arithmetic here.
REQ-003 Parameter NREG, default 8: register-file depth; index width 3.
REQ-004 Parameter TMO, default 64: AU wait-cycle limit (timeout builds only).
REQ-005 clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted on this edge if cmd_valid=1.
REQ-009 cmd_op  in  2  AU ctl_d code; 2'b11 = DIV.
REQ-010 cmd_src  in  9  {ra,rb,rc}: register indices for the R, S and I operands.
REQ-011 cmd_rd  in  3  destination register index.
REQ-012 au_start  out  1  one-cycle start pulse to the AU.
REQ-013 au_r, au_s, au_i  out  W each  operands driven to the AU.
REQ-014 au_ctl_d  out  2  operation select driven to the AU.
REQ-015 au_result  in  W  AU result; valid while au_done=1.
REQ-016 au_done  in  1  AU completion.
REQ-017 au_busy  in  1  AU occupied.
REQ-018 cpl_valid  out  1  one-cycle completion pulse.
REQ-019 cpl_rd  out  3  destination index of the completed command.
REQ-020 cpl_err  out  1  completion carried a timeout.
REQ-021 host_we / host_addr / host_wdata  in  1/3/W  host register write.
REQ-022 host_rdata  out  W  combinational read of regfile[host_addr].

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE->ISSUE on handshake.
- ISSUE->WAIT on the edge au_start is high.
- WAIT->WB on au_done=1.
- WB->IDLE after one cycle.
REQ-024 cmd_ready=1 only in IDLE; zero otherwise.
REQ-025 At handshake, snapshot regfile[ra], regfile[rb], regfile[rc], cmd_op and cmd_rd into operand registers; au_r/au_s/au_i/au_ctl_d come from those registers and stay stable until WB.
REQ-026 In ISSUE, au_start=1 for exactly one cycle, and only when au_busy=0; otherwise wait in ISSUE with au_start=0.
REQ-027 In WAIT, capture au_result on the au_done edge; au_done outside WAIT is ignored.
REQ-028 In WB:
- write captured result to regfile[rd];
- cpl_valid=1 and cpl_rd=rd for that single cycle.
REQ-029 Minimum latency, handshake to cpl_valid = AU latency + 3 cycles; a 24-cycle DIV gives 27.
REQ-030 A host write to a source register after the handshake does not alter in-flight operands.
REQ-031 A host write and WB to the same address in the same cycle: the WB value wins.
REQ-032 Host writes are allowed in every state.

Reset
REQ-033 On rst: FSM->IDLE; cmd_ready=1 from the first cycle after reset.
REQ-034 On rst: au_start, au_r, au_s, au_i, au_ctl_d, cpl_valid, cpl_rd and cpl_err all = 0.
REQ-035 On rst: all regfile entries = 0.
REQ-036 Reset mid-operation drops the in-flight command; no completion, no writeback.

Configuration
REQ-037 With AU_ISSUE_TIMEOUT_EN defined, a counter runs in WAIT. If TMO cycles pass without au_done: cpl_valid=1 and cpl_err=1 with cpl_rd, no writeback, then IDLE.
REQ-038 Without AU_ISSUE_TIMEOUT_EN, WAIT waits indefinitely, cpl_err is tied to 0, and no counter exists.

Structure
REQ-039 Package au_pkg holds:
- W and FRAC constants;
- ctl_d opcode localparams (DIV=2'b11);
- the FSM state enum.
REQ-040 Sub-module au_regfile: NREG x W storage with three synchronous-snapshot read ports plus a combinational host read port, and a single write port with WB priority over host.

Verification
REQ-041 Divide: reg1=0x004000 (1.0), reg2=0x008000 (2.0), DIV r3 <- r1/r2, AU model returns 0x002000 after 24 cycles -> reg3=0x002000; one cpl_valid at cycle 27 with cpl_rd=3; cmd_ready low throughout.
REQ-042 Negative operands: reg1=0x810000 (-4.0), reg2=0x008000, DIV -> reg3=0x808000.
REQ-043 Busy AU: au_busy held high 5 cycles after handshake -> au_start delayed 5 cycles and pulses once.
REQ-044 Host collision: host write 0x00ABCD to r3 on the WB cycle -> reg3 holds the AU result.
REQ-045 Timeout build: AU model never asserts done -> cpl_valid=1 and cpl_err=1 at TMO cycles in WAIT; reg3 unchanged.
REQ-046 Reset mid-WAIT: rst one cycle -> no cpl_valid, all regs 0, and the next command completes normally.
